// File: rtl/comparador_menor_seq.sv
`default_nettype none
// ============================================================================
// Module   : comparador_menor_seq
// Purpose  : Multi-cycle parametrised magnitude comparator (A versus B).
//            Operands are compared CHUNK bits per cycle, most significant
//            chunk first. Supports unsigned (sltu) and two's-complement
//            (slt) modes. Produces the "A menor" mask (all ones when A<B)
//            and one-hot lt/eq/gt flags.
//
// Parameters:
//   WIDTH  - operand width in bits (default 32)
//   CHUNK  - bits compared per cycle; WIDTH must be a multiple of CHUNK
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous, active-high reset
//   in_valid    in   operands valid
//   in_ready    out  unit can accept operands (IDLE and not in reset)
//   A, B        in   operands, WIDTH bits
//   signed_mode in   1 = two's-complement compare, sampled with operands
//   out_valid   out  result valid, held until out_ready
//   out_ready   in   consumer accepts result
//   Amenor      out  all ones if A<B, else all zeros
//   lt, eq, gt  out  exactly one is set while out_valid=1
//
// Build option:
//   COMPARADOR_EARLY_EXIT_EN - when defined, RUN ends on the cycle the first
//   differing chunk is found; otherwise RUN always lasts WIDTH/CHUNK cycles.
//   Results are identical in both builds.
//
// Revision : 1.0 - initial release
// ============================================================================
module comparador_menor_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Amenor,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             decided_q,   decided_d;
  logic             run_lt_q,    run_lt_d;
  logic             run_gt_q,    run_gt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] amenor_q,    amenor_d;
  logic             lt_q,        lt_d;
  logic             eq_q,        eq_d;
  logic             gt_q,        gt_d;

  // --------------------------------------------------------------------------
  // Split the latched operands into chunks so the current chunk can be picked
  // with a plain array index driven by the counter.
  // --------------------------------------------------------------------------
  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunks
    assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
  end

  logic [CHUNK-1:0] cur_a;
  logic [CHUNK-1:0] cur_b;
  logic             chunk_diff;
  logic             chunk_lt;
  logic             first_diff;
  logic             run_finish;

  assign cur_a      = a_chunk[cnt_q];
  assign cur_b      = b_chunk[cnt_q];
  assign chunk_diff = (cur_a != cur_b);
  assign chunk_lt   = (cur_a < cur_b);
  // Only the most significant differing chunk decides the result.
  assign first_diff = !decided_q && chunk_diff;

`ifdef COMPARADOR_EARLY_EXIT_EN
  assign run_finish = (cnt_q == '0) || first_diff;
`else
  assign run_finish = (cnt_q == '0);
`endif

  // in_ready is decoded from state and forced low during reset.
  assign in_ready = (state_q == S_IDLE) && !rst;

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    decided_d   = decided_q;
    run_lt_d    = run_lt_q;
    run_gt_d    = run_gt_q;
    out_valid_d = out_valid_q;
    amenor_d    = amenor_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = A;
          b_d = B;
          // Flipping the sign bit of both operands maps two's-complement
          // ordering onto unsigned ordering.
          if (signed_mode) begin
            a_d[WIDTH-1] = ~A[WIDTH-1];
            b_d[WIDTH-1] = ~B[WIDTH-1];
          end
          cnt_d     = CNT_LAST;
          decided_d = 1'b0;
          run_lt_d  = 1'b0;
          run_gt_d  = 1'b0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (first_diff) begin
          decided_d = 1'b1;
          run_lt_d  = chunk_lt;
          run_gt_d  = !chunk_lt;
        end
        if (run_finish) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          lt_d        = run_lt_d;
          gt_d        = run_gt_d;
          eq_d        = !decided_d;
          amenor_d    = {WIDTH{run_lt_d}};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        // Result registers hold untouched until the consumer takes them.
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          lt_d        = 1'b0;
          eq_d        = 1'b0;
          gt_d        = 1'b0;
          amenor_d    = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      run_lt_q    <= 1'b0;
      run_gt_q    <= 1'b0;
      out_valid_q <= 1'b0;
      amenor_q    <= '0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      decided_q   <= decided_d;
      run_lt_q    <= run_lt_d;
      run_gt_q    <= run_gt_d;
      out_valid_q <= out_valid_d;
      amenor_q    <= amenor_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Amenor    = amenor_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;

endmodule
`default_nettype wire
